pe_context_sequencer: RTL and testbench

Parametrised successor to the per-PE context cache plus context pointer pair. Holds DEPTH configuration words of CTX_WIDTH bits, loaded through a write port. On start it issues a program of cfg_len contexts to the PE decode buffer, repeating the program cfg_iters times (0 = run until abort). Adds stall, abort, iteration count and a done/error status, none of which the existing cache/pointer pair provides.

---
 rtl/pe_ctx_pkg.sv | 15 +
 rtl/pe_ctx_mem.sv | 36 +++
 rtl/pe_context_sequencer.sv | 140 ++++++++++++++
 tb/tb_pe_context_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctx_pkg.sv
// Shared types and constants for the PE context sequencer and its storage.
package pe_ctx_pkg;

   localparam int CTX_WIDTH_DEFAULT = 121;
   localparam int CTX_DEPTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [CTX_WIDTH_DEFAULT-1:0] ctx_word_t;

endpackage

// File: rtl/pe_ctx_mem.sv
// Context storage: DEPTH x CTX_WIDTH, one synchronous write port and one
// registered read port whose output register holds between reads.
module pe_ctx_mem
   import pe_ctx_pkg::*;
#(
   parameter  int CTX_WIDTH = CTX_WIDTH_DEFAULT,
   parameter  int DEPTH     = CTX_DEPTH_DEFAULT,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_we,
   input  logic [AW-1:0]        i_waddr,
   input  logic [CTX_WIDTH-1:0] i_wdata,
   input  logic                 i_re,
   input  logic [AW-1:0]        i_raddr,
   output logic [CTX_WIDTH-1:0] o_rdata
);

   logic [CTX_WIDTH-1:0] r_mem [DEPTH];
   logic [CTX_WIDTH-1:0] r_rdata;

   // NOTE: the array has no reset so it maps onto RAM; contents survive RST_N.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // The read register is the visible context output, so it alone is reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/pe_context_sequencer.sv
// Issues a loaded program of contexts to the PE decode buffer, repeating it a
// configurable number of times, with stall, abort and done/error status.
module pe_context_sequencer
   import pe_ctx_pkg::*;
#(
   parameter  int CTX_WIDTH = CTX_WIDTH_DEFAULT,
   parameter  int DEPTH     = CTX_DEPTH_DEFAULT,
   parameter  int ITER_W    = 8,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 cfg_we,
   input  logic [AW-1:0]        cfg_addr,
   input  logic [CTX_WIDTH-1:0] cfg_data,
   input  logic [AW:0]          cfg_len,
   input  logic [ITER_W-1:0]    cfg_iters,
   input  logic                 start,
   input  logic                 stall,
   input  logic                 abort,
   output logic [CTX_WIDTH-1:0] ctx_out,
   output logic                 ctx_valid,
   output logic [AW-1:0]        cp,
   output logic [ITER_W-1:0]    iter_cnt,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err
);

   localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

   state_t            r_state;
   logic [AW-1:0]     r_rp;
   logic [AW:0]       r_len;
   logic [ITER_W-1:0] r_iters;
   logic [ITER_W-1:0] r_iter_cnt;
   logic [AW-1:0]     r_cp;
   logic              r_valid, r_busy, r_done, r_cfg_err;

   logic w_idle_or_done, w_len_ok, w_addr_ok;
   logic w_start_ok, w_start_bad, w_wr_ok, w_wr_bad;
   logic w_issue, w_wrap, w_last;

   assign w_idle_or_done = (r_state != RUN);
   assign w_len_ok       = (cfg_len != '0) && (cfg_len <= DEPTH_V);
   assign w_addr_ok      = ({1'b0, cfg_addr} < DEPTH_V);

   // Abort outranks start, so a start under abort is neither taken nor flagged.
   assign w_start_ok  = start && w_idle_or_done && !abort && w_len_ok;
   assign w_start_bad = start && w_idle_or_done && !abort && !w_len_ok;
   assign w_wr_ok     = cfg_we && w_idle_or_done && w_addr_ok;
   assign w_wr_bad    = cfg_we && (!w_idle_or_done || !w_addr_ok);

   assign w_issue = (r_state == RUN) && !stall && !abort;
   assign w_wrap  = ({1'b0, r_rp} == (r_len - 1'b1));
   assign w_last  = w_wrap && (r_iters != '0) && (r_iter_cnt == (r_iters - 1'b1));

   pe_ctx_mem #(
      .CTX_WIDTH (CTX_WIDTH),
      .DEPTH     (DEPTH)
   ) u_mem (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_we    (w_wr_ok),
      .i_waddr (cfg_addr),
      .i_wdata (cfg_data),
      .i_re    (w_issue),
      .i_raddr (r_rp),
      .o_rdata (ctx_out)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= IDLE;
         r_rp       <= '0;
         r_len      <= '0;
         r_iters    <= '0;
         r_iter_cnt <= '0;
         r_cp       <= '0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_cfg_err  <= 1'b0;
      end else begin
         r_cfg_err <= w_start_bad || w_wr_bad;
         if (abort) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rp    <= '0;
         end else begin
            case (r_state)
               IDLE, DONE: begin
                  r_valid <= 1'b0;
                  if (w_start_ok) begin
                     r_state    <= RUN;
                     r_len      <= cfg_len;
                     r_iters    <= cfg_iters;
                     r_iter_cnt <= '0;
                     r_rp       <= '0;
                     r_done     <= 1'b0;
                     r_busy     <= 1'b1;
                  end
               end
               RUN: begin
                  if (stall) begin
                     r_valid <= 1'b0;
                  end else begin
                     r_valid <= 1'b1;
                     r_cp    <= r_rp;
                     if (w_wrap) begin
                        r_rp       <= '0;
                        r_iter_cnt <= r_iter_cnt + 1'b1;
                        if (w_last) begin
                           r_state <= DONE;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                        end
                     end else begin
                        r_rp <= r_rp + 1'b1;
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign ctx_valid = r_valid;
   assign cp        = r_cp;
   assign iter_cnt  = r_iter_cnt;
   assign busy      = r_busy;
   assign done      = r_done;
   assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_pe_context_sequencer.sv
// Directed self-checking bench for pe_context_sequencer (default parameters).
module tb_pe_context_sequencer;

   localparam int CTX_WIDTH = 121;
   localparam int DEPTH     = 16;
   localparam int ITER_W    = 8;
   localparam int AW        = 4;

   logic                 CLK = 1'b0;
   logic                 RST_N;
   logic                 cfg_we;
   logic [AW-1:0]        cfg_addr;
   logic [CTX_WIDTH-1:0] cfg_data;
   logic [AW:0]          cfg_len;
   logic [ITER_W-1:0]    cfg_iters;
   logic                 start, stall, abort;
   logic [CTX_WIDTH-1:0] ctx_out;
   logic                 ctx_valid;
   logic [AW-1:0]        cp;
   logic [ITER_W-1:0]    iter_cnt;
   logic                 busy, done, cfg_err;

   int n_checks = 0;
   int n_fail   = 0;

   pe_context_sequencer #(
      .CTX_WIDTH (CTX_WIDTH),
      .DEPTH     (DEPTH),
      .ITER_W    (ITER_W)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_len   (cfg_len),
      .cfg_iters (cfg_iters),
      .start     (start),
      .stall     (stall),
      .abort     (abort),
      .ctx_out   (ctx_out),
      .ctx_valid (ctx_valid),
      .cp        (cp),
      .iter_cnt  (iter_cnt),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle; inputs set after this are stable for the next edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [CTX_WIDTH-1:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic launch(input logic [AW:0] len, input logic [ITER_W-1:0] its);
      cfg_len = len; cfg_iters = its; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic go_idle();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [CTX_WIDTH-1:0] exp_w;
      int n_iss;

      RST_N = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      cfg_len = '0; cfg_iters = '0; start = 1'b0; stall = 1'b0; abort = 1'b0;
      tick(); tick();
      check("rst_ctx_out", ctx_out, 0);
      check("rst_valid", ctx_valid, 0);
      check("rst_cp", cp, 0);
      check("rst_iter", iter_cnt, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", cfg_err, 0);
      RST_N = 1'b1;
      tick();

      // Basic two-pass program over slots 0..3.
      for (int i = 0; i < 4; i++) wr(AW'(i), CTX_WIDTH'(8'hA0 + i));
      launch(5'd4, 8'd2);
      check("t1_busy", busy, 1);
      check("t1_dead_cycle", ctx_valid, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("t1_valid", ctx_valid, 1);
         check("t1_ctx", ctx_out, 128'hA0 + 128'(i % 4));
         check("t1_cp", cp, 128'(i % 4));
      end
      check("t1_iter", iter_cnt, 2);
      check("t1_done", done, 1);
      check("t1_busy_end", busy, 0);
      tick();
      check("t1_done_valid", ctx_valid, 0);
      check("t1_done_hold", ctx_out, 128'hA3);

      // Stall for three cycles while cp=1.
      launch(5'd4, 8'd2);
      tick();
      check("t2_a0", ctx_out, 128'hA0);
      tick();
      check("t2_a1", ctx_out, 128'hA1);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_stall_valid", ctx_valid, 0);
         check("t2_stall_ctx", ctx_out, 128'hA1);
         check("t2_stall_cp", cp, 1);
      end
      stall = 1'b0;
      tick();
      check("t2_resume", ctx_out, 128'hA2);
      n_iss = 3;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ctx_valid) n_iss++;
         if (done) break;
      end
      check("t2_done", done, 1);
      check("t2_issue_count", 128'(n_iss), 8);

      // Infinite mode, then abort while stalled.
      launch(5'd3, 8'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t3_ctx", ctx_out, 128'hA0 + 128'(i % 3));
      end
      check("t3_no_done", done, 0);
      check("t3_iter_pre", iter_cnt, 3);
      stall = 1'b1; abort = 1'b1;
      tick();
      stall = 1'b0; abort = 1'b0;
      check("t3_busy", busy, 0);
      check("t3_valid", ctx_valid, 0);
      check("t3_done", done, 0);
      check("t3_iter_hold", iter_cnt, 3);
      check("t3_ctx_hold", ctx_out, 128'hA0);

      // Write during RUN is rejected and leaves old data in slot 2.
      launch(5'd4, 8'd1);
      cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = CTX_WIDTH'(8'hFF);
      tick();
      cfg_we = 1'b0;
      check("t4_wr_err", cfg_err, 1);
      check("t4_a0", ctx_out, 128'hA0);
      tick();
      check("t4_err_once", cfg_err, 0);
      tick();
      check("t4_old_data", ctx_out, 128'hA2);
      tick();
      check("t4_done", done, 1);
      go_idle();

      // Bad lengths are rejected in IDLE.
      launch(5'd0, 8'd1);
      check("t4_len0_err", cfg_err, 1);
      check("t4_len0_busy", busy, 0);
      launch(5'd17, 8'd1);
      check("t4_len17_err", cfg_err, 1);
      check("t4_len17_busy", busy, 0);
      tick();
      check("t4_err_clear", cfg_err, 0);
      check("t4_idle_valid", ctx_valid, 0);

      // Full-depth program.
      for (int i = 4; i < DEPTH; i++) wr(AW'(i), CTX_WIDTH'(8'hB0 + i));
      launch(5'd16, 8'd1);
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         exp_w = (i < 4) ? CTX_WIDTH'(8'hA0 + i) : CTX_WIDTH'(8'hB0 + i);
         check("t4_full_ctx", ctx_out, 128'(exp_w));
      end
      check("t4_full_cp", cp, 15);
      check("t4_full_iter", iter_cnt, 1);
      check("t4_full_done", done, 1);
      go_idle();

      // Write and start in the same cycle: the issue sees the new data.
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = CTX_WIDTH'(8'h55);
      launch(5'd1, 8'd1);
      cfg_we = 1'b0;
      check("t5_no_err", cfg_err, 0);
      tick();
      check("t5_valid", ctx_valid, 1);
      check("t5_ctx", ctx_out, 128'h55);
      check("t5_done", done, 1);
      tick();
      check("t5_single", ctx_valid, 0);

      // Reset mid-RUN, then restart with retained memory.
      launch(5'd4, 8'd1);
      tick(); tick();
      check("t6_pre_ctx", ctx_out, 128'hA1);
      RST_N = 1'b0;
      #1;
      check("t6_rst_ctx", ctx_out, 0);
      check("t6_rst_valid", ctx_valid, 0);
      check("t6_rst_cp", cp, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_iter", iter_cnt, 0);
      tick();
      RST_N = 1'b1;
      tick();
      check("t6_idle", busy, 0);
      launch(5'd4, 8'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_w = (i == 0) ? CTX_WIDTH'(8'h55) : CTX_WIDTH'(8'hA0 + i);
         check("t6_reissue", ctx_out, 128'(exp_w));
      end
      check("t6_done", done, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
